// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic [5:0] StallNone = 6'b000000;
   localparam logic [5:0] StallId   = 6'b000111;
   localparam logic [5:0] StallEx   = 6'b001111;

   localparam logic RstEnableN = 1'b0;

   typedef enum logic {
      CtrlRun   = 1'b0,
      CtrlFlush = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// EX-stall watchdog: saturating consecutive-stall counter with a sticky timeout flag.
module stall_watchdog
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_MAX = 64,
   parameter int CNT_W     = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic stallreq_ex_i,
   input  logic flush_entry_i,
   output logic timeout_o
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STALL_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   // Next counter value; a flush entry or a gap in EX-busy restarts the count.
   always_comb begin
      cnt_d = cnt_q;
      if (flush_entry_i || !stallreq_ex_i) begin
         cnt_d = '0;
      end else if (run_i && (cnt_q != MaxCnt)) begin
         cnt_d = cnt_q + 1'b1;
      end
      timeout_d = timeout_q | (cnt_d == MaxCnt);
   end

   // Counter and sticky flag registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst == RstEnableN) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, exception flush, EX watchdog.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------
// CtrlRun   | normal issue; stalls follow hazard requests
// CtrlFlush | one-cycle flush pulse with handler PC; stalls masked
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_MAX = 64,
   parameter int CNT_W     = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        excpt_req,
   input  logic [31:0] excpt_pc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [15:0] perf_flush_count
`endif
);

   ctrl_state_e state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic        flush_entry;

   // Next-state and registered flush/new_pc; exceptions are only taken in RUN.
   always_comb begin
      state_d     = state_q;
      flush_d     = 1'b0;
      new_pc_d    = new_pc_q;
      flush_entry = 1'b0;
      case (state_q)
         CtrlRun: begin
            if (excpt_req) begin
               state_d     = CtrlFlush;
               flush_d     = 1'b1;
               new_pc_d    = excpt_pc;
               flush_entry = 1'b1;
            end
         end
         CtrlFlush: state_d = CtrlRun;
         default:   state_d = CtrlRun;
      endcase
   end

   // Same-cycle stall vector; reset and FLUSH both force all stages to run.
   always_comb begin
      stall = StallNone;
      if (rst == RstEnableN || state_q == CtrlFlush) begin
         stall = StallNone;
      end else if (stallreq_ex) begin
         stall = StallEx;
      end else if (stallreq_id) begin
         stall = StallId;
      end
   end

   // State, flush pulse and handler PC registers.
   always_ff @(posedge clk) begin
      if (rst == RstEnableN) begin
         state_q  <= CtrlRun;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
      end
   end

   assign flush  = flush_q;
   assign new_pc = new_pc_q;

   stall_watchdog #(
      .STALL_MAX (STALL_MAX),
      .CNT_W     (CNT_W)
   ) u_stall_watchdog (
      .clk           (clk),
      .rst           (rst),
      .run_i         (state_q == CtrlRun),
      .stallreq_ex_i (stallreq_ex),
      .flush_entry_i (flush_entry),
      .timeout_o     (stall_timeout)
   );

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q;
   logic [15:0] perf_flush_q;

   // Free-running, wrapping counters of stalled cycles and flush entries.
   always_ff @(posedge clk) begin
      if (rst == RstEnableN) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall != StallNone) perf_stall_q <= perf_stall_q + 32'd1;
         if (flush_entry)        perf_flush_q <= perf_flush_q + 16'd1;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expectations, monitor checks at negedge.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id, stallreq_ex, excpt_req;
   logic [31:0] excpt_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [15:0] perf_flush_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       name;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] pc;
      logic        to;
      bit          perf;
      logic [31:0] ps;
      logic [15:0] pf;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pipe_ctrl #(.STALL_MAX(4), .CNT_W(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .stallreq_id       (stallreq_id),
      .stallreq_ex       (stallreq_ex),
      .excpt_req         (excpt_req),
      .excpt_pc          (excpt_pc),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .stall_timeout     (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
`endif
   );

   // One cycle: drive inputs just after posedge, queue the mid-cycle expectation.
   task automatic cyc(input logic r, input logic id, input logic ex, input logic exc,
                      input logic [31:0] pc, input string name,
                      input logic [5:0] est, input logic efl, input logic [31:0] epc,
                      input logic eto, input bit perf = 0,
                      input logic [31:0] eps = 0, input logic [15:0] epf = 0);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; stallreq_id = id; stallreq_ex = ex; excpt_req = exc; excpt_pc = pc;
      e.name = name; e.st = est; e.fl = efl; e.pc = epc; e.to = eto;
      e.perf = perf; e.ps = eps; e.pf = epf;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs against the oldest expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (stall !== e.st || flush !== e.fl || new_pc !== e.pc || stall_timeout !== e.to) begin
            miscompares++;
            $display("FAIL %s: got stall=%b flush=%b new_pc=%h timeout=%b, want stall=%b flush=%b new_pc=%h timeout=%b",
                     e.name, stall, flush, new_pc, stall_timeout, e.st, e.fl, e.pc, e.to);
         end
`ifdef PIPE_CTRL_PERF_EN
         if (e.perf) begin
            vectors++;
            if (perf_stall_cycles !== e.ps || perf_flush_count !== e.pf) begin
               miscompares++;
               $display("FAIL %s_perf: got stall_cycles=%0d flush_count=%0d, want %0d %0d",
                        e.name, perf_stall_cycles, perf_flush_count, e.ps, e.pf);
            end
         end
`endif
      end
   end

   initial begin
      rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b1; excpt_req = 1'b1; excpt_pc = 32'h99;
      // reset with requests asserted
      cyc(0, 0, 1, 1, 32'h99, "reset1", 6'b000000, 0, 32'h0, 0);
      cyc(0, 0, 1, 1, 32'h99, "reset2", 6'b000000, 0, 32'h0, 0);
      cyc(1, 0, 1, 0, 32'h0,  "rst_release_ex", 6'b001111, 0, 32'h0, 0);
      // priority
      cyc(1, 1, 1, 0, 32'h0, "prio_id_ex", 6'b001111, 0, 32'h0, 0);
      cyc(1, 1, 0, 0, 32'h0, "prio_id",    6'b000111, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 32'h0, "prio_none",  6'b000000, 0, 32'h0, 0);
      // single exception; stall requests masked during FLUSH
      cyc(1, 0, 0, 1, 32'h20, "exc_issue", 6'b000000, 0, 32'h0,  0);
      cyc(1, 1, 1, 0, 32'h0,  "exc_flush", 6'b000000, 1, 32'h20, 0);
      cyc(1, 0, 0, 0, 32'h0,  "exc_after", 6'b000000, 0, 32'h20, 0);
      // back-to-back exception requests
      cyc(1, 0, 0, 1, 32'h60, "b2b_first",  6'b000000, 0, 32'h20, 0);
      cyc(1, 0, 0, 1, 32'h40, "b2b_flush",  6'b000000, 1, 32'h60, 0);
      cyc(1, 0, 0, 0, 32'h0,  "b2b_after",  6'b000000, 0, 32'h60, 0);
      cyc(1, 0, 0, 0, 32'h0,  "b2b_after2", 6'b000000, 0, 32'h60, 0);
      // watchdog: 3 cycles does not trip
      cyc(1, 0, 1, 0, 32'h0, "wd3_c1",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 1, 0, 32'h0, "wd3_c2",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 1, 0, 32'h0, "wd3_c3",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 0, 0, 32'h0, "wd3_drop", 6'b000000, 0, 32'h60, 0);
      cyc(1, 0, 0, 0, 32'h0, "wd3_idle", 6'b000000, 0, 32'h60, 0);
      // watchdog: 4 cycles trips, sticky through flush
      cyc(1, 0, 1, 0, 32'h0, "wd4_c1",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 1, 0, 32'h0, "wd4_c2",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 1, 0, 32'h0, "wd4_c3",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 1, 0, 32'h0, "wd4_c4",   6'b001111, 0, 32'h60, 0);
      cyc(1, 0, 0, 0, 32'h0, "wd4_trip", 6'b000000, 0, 32'h60, 1);
      cyc(1, 0, 0, 1, 32'h300, "wd4_exc",   6'b000000, 0, 32'h60,  1);
      cyc(1, 0, 0, 0, 32'h0,   "wd4_flush", 6'b000000, 1, 32'h300, 1);
      cyc(1, 0, 0, 0, 32'h0,   "wd4_post",  6'b000000, 0, 32'h300, 1);
      // reset during FLUSH discards a pending exception
      cyc(1, 0, 0, 1, 32'h500, "rf_exc",   6'b000000, 0, 32'h300, 1);
      cyc(0, 0, 0, 1, 32'h700, "rf_flush", 6'b000000, 1, 32'h500, 1);
      cyc(1, 0, 0, 0, 32'h0,   "rf_post",  6'b000000, 0, 32'h0,   0);
      // reset during an EX stall
      cyc(1, 0, 1, 0, 32'h0, "rs_stall", 6'b001111, 0, 32'h0, 0);
      cyc(0, 0, 1, 0, 32'h0, "rs_rst",   6'b000000, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 32'h0, "rs_post",  6'b000000, 0, 32'h0, 0, 1, 32'd0, 16'd0);
      // perf: 5 stalled cycles and one flush
      for (int i = 0; i < 5; i++)
         cyc(1, 1, 0, 0, 32'h0, "perf_stall", 6'b000111, 0, 32'h0, 0);
      cyc(1, 0, 0, 1, 32'h10, "perf_exc",   6'b000000, 0, 32'h0,  0, 1, 32'd5, 16'd0);
      cyc(1, 0, 0, 0, 32'h0,  "perf_flush", 6'b000000, 1, 32'h10, 0, 1, 32'd5, 16'd1);
      cyc(1, 0, 0, 0, 32'h0,  "perf_end",   6'b000000, 0, 32'h10, 0, 1, 32'd5, 16'd1);
      // drain scoreboard with a bound
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
